// File: rtl/debug_commit_scheduler_if.sv
// debug_commit_scheduler_if: commit port from the core and record port to the debug sink
interface debug_commit_scheduler_if;
  logic        commit_valid;
  logic        commit_ready;
  logic        commit_halt;
  logic        commit_deviceAccess;
  logic [31:0] commit_deviceAddr;
  logic [31:0] commit_pc;
  logic        commit_regWen;
  logic [4:0]  commit_regWaddr;
  logic [31:0] commit_regWdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_deviceAccess;
  logic [31:0] out_deviceAddr;
  logic [31:0] out_nextPc;
  logic        out_regWen;
  logic [4:0]  out_regWaddr;
  logic [31:0] out_regWdata;
  modport master (
    output commit_valid, commit_halt, commit_deviceAccess, commit_deviceAddr, commit_pc,
           commit_regWen, commit_regWaddr, commit_regWdata, out_ready,
    input  commit_ready, out_valid, out_deviceAccess, out_deviceAddr, out_nextPc,
           out_regWen, out_regWaddr, out_regWdata
  );
  modport slave (
    input  commit_valid, commit_halt, commit_deviceAccess, commit_deviceAddr, commit_pc,
           commit_regWen, commit_regWaddr, commit_regWdata, out_ready,
    output commit_ready, out_valid, out_deviceAccess, out_deviceAddr, out_nextPc,
           out_regWen, out_regWaddr, out_regWdata
  );
endinterface

// File: rtl/debug_commit_scheduler.sv
// debug_commit_scheduler: pairs commit side effects with the next retired PC, queues them, sequences halt
module debug_commit_scheduler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  debug_commit_scheduler_if.slave bus,
  output logic                 sim_halt,
  output logic [CNT_W-1:0]     count,
  output logic                 halted
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic        da;
    logic [31:0] addr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } hold_t;
  typedef struct packed {
    hold_t       h;
    logic [31:0] npc;
  } rec_t;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
  state_e           state_q, state_d;
  rec_t             mem_q [DEPTH];
  hold_t            hold_q;
  logic             hold_v_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    wr_q, rd_q;
  logic             sim_halt_q;
  logic             acc, push, pop;
  hold_t            cur;
  assign cur = '{da: bus.commit_deviceAccess, addr: bus.commit_deviceAddr, wen: bus.commit_regWen,
                 waddr: bus.commit_regWaddr, wdata: bus.commit_regWdata};
  assign bus.commit_ready = (state_q == RUN) && (count_q < CNT_W'(DEPTH));
  assign bus.out_valid    = count_q != '0;
  assign acc  = bus.commit_valid && bus.commit_ready;
  assign push = acc && hold_v_q;
  assign pop  = bus.out_valid && bus.out_ready;
  assign bus.out_deviceAccess = mem_q[rd_q].h.da;
  assign bus.out_deviceAddr   = mem_q[rd_q].h.addr;
  assign bus.out_regWen       = mem_q[rd_q].h.wen;
  assign bus.out_regWaddr     = mem_q[rd_q].h.waddr;
  assign bus.out_regWdata     = mem_q[rd_q].h.wdata;
  assign bus.out_nextPc       = mem_q[rd_q].npc;
  assign sim_halt = sim_halt_q;
  assign count    = count_q;
  assign halted   = state_q == HALTED;
  always_comb begin
    state_d = (state_q == RUN && acc && bus.commit_halt) ? DRAIN :
              (state_q == DRAIN && count_q == '0)        ? HALTED : state_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      sim_halt_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sim_halt_q <= state_q == DRAIN && count_q == '0;
      if (push) begin
        mem_q[wr_q] <= '{h: hold_q, npc: bus.commit_pc};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      // the halt instruction itself is never paired, so it only clears the hold
      if (acc) begin
        hold_v_q <= !bus.commit_halt;
        if (!bus.commit_halt) hold_q <= cur;
      end
    end
  end
endmodule
